// File: rtl/cntr8_pkg.sv
// Shared types and helpers for the shared 8-bit counter controller.
package cntr8_pkg;

  localparam int CNTR_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_res_t;

  // Round-robin search: first valid index after 'last', wrapping modulo n.
  function automatic rr_res_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         last,
                                      input int                 n);
    rr_res_t res;
    int      cand;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = (int'(last) + k) % n;
      if ((k <= n) && !res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = 3'(cand);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cntr8_share_ctrl_if.sv
// Request/grant/status bundle between client blocks and the counter scheduler.
interface cntr8_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
) ();
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_len;
  logic [NREQ-1:0]   req_ready;
  logic              abort;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [IW-1:0]     owner;
  logic [W-1:0]      count;

  // Client side: raises requests and abort, observes grants and status.
  modport master (
    output req_valid, req_len, abort,
    input  req_ready, done, busy, owner, count
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_len, abort,
    output req_ready, done, busy, owner, count
  );
endinterface

// File: rtl/cntr8_core.sv
// W-bit up-counter datapath; clear takes priority over enable.
module cntr8_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Counter register: clear, else increment when enabled, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cntr8_share_ctrl.sv
// Round-robin scheduler granting one shared counter to NREQ requesters.
module cntr8_share_ctrl
  import cntr8_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CNTR_W
) (
  input logic               clk,
  input logic               rst,
  cntr8_share_ctrl_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_len;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  rr_res_t         w_pick;
  logic [IW-1:0]   w_sel;
  logic            w_hs;
  logic [W-1:0]    w_len_in;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_done;
  logic            w_clr;
  logic            w_en;
  logic [W-1:0]    w_count;

  cntr8_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_count(w_count)
  );

  // Arbitration: pick the next requester after the last grant; only offered in IDLE.
  always_comb begin
    w_pick   = rr_pick(MAX_REQ'(bus.req_valid), 3'(r_last), NREQ);
    w_sel    = IW'(w_pick.idx);
    w_hs     = (r_state == IDLE) && w_pick.found;
    w_len_in = bus.req_len[w_sel*W +: W];
    w_ready  = '0;
    if (w_hs) begin
      w_ready[w_sel] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Completion pulse to the owner in DONE; an abort in that cycle swallows it.
  always_comb begin
    w_done = '0;
    if ((r_state == DONE) && !bus.abort) begin
      w_done[r_owner] = 1'b1;
    end else begin
      w_done = '0;
    end
  end

  // Next-state and counter control; zero-length grants skip RUN entirely.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (w_hs) begin
          w_state_nxt = (w_len_in != '0) ? RUN : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
        end else begin
          w_en = 1'b1;
          if (w_count == (r_len - W'(1))) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_clr       = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_clr       = 1'b1;
      end
    endcase
  end

  // State, latched length, owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_len   <= w_len_in;
        r_owner <= w_sel;
        r_last  <= w_sel;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.done      = w_done;
  assign bus.busy      = (r_state != IDLE);
  assign bus.owner     = r_owner;
  assign bus.count     = w_count;

endmodule

// File: tb/tb_cntr8_share_ctrl.sv
// Self-checking bench for cntr8_share_ctrl against a timeline-based reference model.
module tb_cntr8_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IW   = 2;
  localparam int VW   = NREQ + NREQ + 1 + IW + W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cntr8_share_ctrl_if #(.NREQ(NREQ), .W(W)) bif ();
  cntr8_share_ctrl #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bif));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an interval is described by how many cycles ago it was accepted.
  bit m_active;
  int m_k;
  int m_len;
  int m_owner;
  int m_last;

  logic [NREQ-1:0] e_ready, e_done;
  logic            e_busy;
  logic [IW-1:0]   e_owner;
  logic [W-1:0]    e_count;

  function automatic void model_reset();
    m_active = 1'b0; m_k = 0; m_len = 0; m_owner = 0; m_last = NREQ - 1;
  endfunction

  function automatic int winner();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (bif.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] obs();
    return {bif.req_ready, bif.done, bif.busy, bif.owner, bif.count};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {e_ready, e_done, e_busy, e_owner, e_count};
  endfunction

  task automatic set_in(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] l, input logic a);
    bif.req_valid = v; bif.req_len = l; bif.abort = a;
  endtask

  // Let inputs settle, then derive this cycle's expected outputs.
  task automatic eval();
    int w;
    #1;
    e_ready = '0; e_done = '0; e_busy = 1'b0; e_count = '0;
    e_owner = IW'(m_owner);
    if (m_active) begin
      e_busy  = 1'b1;
      e_count = (m_k == m_len + 1) ? W'(m_len) : W'(m_k - 1);
      if (m_k == m_len + 1 && !bif.abort) e_done[m_owner] = 1'b1;
    end else begin
      w = winner();
      if (w >= 0) e_ready[w] = 1'b1;
    end
  endtask

  // Apply this cycle's inputs to the model, then clock once.
  task automatic advance();
    int w;
    if (m_active) begin
      if (bif.abort || m_k == m_len + 1) m_active = 1'b0;
      else m_k++;
    end else begin
      w = winner();
      if (w >= 0) begin
        m_active = 1'b1; m_k = 1; m_len = int'(bif.req_len[w*W +: W]);
        m_owner = w; m_last = w;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    set_in('0, '0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (!m_active) break;
      advance();
    end
  endtask

  task automatic test_reset();
    eval();
    n_vec++;
    if (obs() !== {VW{1'b0}}) begin
      n_err++; $display("FAIL reset_vals got %h exp %h", obs(), {VW{1'b0}});
    end
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL reset_model got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_len3();
    drain();
    set_in(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);
    for (int i = 0; i < 7; i++) begin
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL len3 cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
      bif.req_valid = 4'b0000;
    end
  endtask

  task automatic test_len0();
    drain();
    set_in(4'b0100, {8'd9, 8'd0, 8'd9, 8'd9}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL len0 cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
      bif.req_valid = 4'b0000;
    end
  endtask

  task automatic test_all_valid();
    drain();
    set_in(4'b1111, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    for (int i = 0; i < 16; i++) begin
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL rr_all cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_abort();
    bit aborted;
    aborted = 1'b0;
    drain();
    set_in(4'b0010, {8'd0, 8'd2, 8'd10, 8'd0}, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bif.abort = (m_active && m_len == 10 && m_k == 6 && !aborted);
      if (aborted) bif.req_valid = 4'b0110;
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL abort cyc %0d got %h exp %h", i, obs(), expv());
      end
      if (bif.abort) aborted = 1'b1;
      advance();
    end
  endtask

  task automatic test_async_rst();
    drain();
    set_in(4'b0001, {8'd0, 8'd0, 8'd0, 8'd20}, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (m_active && m_k == 8) break;
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL arst_pre cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
      bif.req_valid = 4'b0000;
    end
    n_vec++;
    if (bif.count !== 8'd7) begin
      n_err++; $display("FAIL arst_cnt7 got %0d exp %0d", bif.count, 7);
    end
    #2;
    rst = 1'b1;
    model_reset();
    eval();
    n_vec++;
    if (obs() !== {VW{1'b0}}) begin
      n_err++; $display("FAIL arst_zero got %h exp %h", obs(), {VW{1'b0}});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_in(4'b1001, {8'd5, 8'd0, 8'd0, 8'd2}, 1'b0);
    for (int i = 0; i < 6; i++) begin
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL arst_post cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
      bif.req_valid = 4'b0000;
    end
  endtask

  task automatic test_len255();
    drain();
    set_in(4'b1000, {8'd255, 8'd0, 8'd0, 8'd0}, 1'b0);
    for (int i = 0; i < 260; i++) begin
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL len255 cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
      bif.req_valid = 4'b0000;
    end
  endtask

  task automatic test_random();
    logic [NREQ*W-1:0] l;
    drain();
    for (int i = 0; i < 500; i++) begin
      for (int j = 0; j < NREQ; j++) l[j*W +: W] = W'($urandom_range(0, 6));
      set_in(NREQ'($urandom_range(0, 15)), l, ($urandom_range(0, 7) == 0));
      eval();
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL random cyc %0d got %h exp %h", i, obs(), expv());
      end
      advance();
    end
  endtask

  // Test sequence.
  initial begin
    rst = 1'b1;
    set_in('0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_len3();
    test_len0();
    test_all_valid();
    test_abort();
    test_async_rst();
    test_len255();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
